// File: rtl/riscv_trace_pkg.sv
// Shared types and constants for the retire-trace capture unit.
package riscv_trace_pkg;

  localparam int TRC_DATA_W = 32;
  localparam int TRC_ADDR_W = 9;
  localparam int TRC_REG_W  = 5;
  localparam int TRC_SEQ_W  = 16;

  localparam int FLG_REG_WR = 0;
  localparam int FLG_MEM_WR = 1;
  localparam int FLG_MEM_RD = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [TRC_SEQ_W-1:0]  seq;
    logic [2:0]            flags;
    logic [TRC_REG_W-1:0]  reg_num;
    logic [TRC_DATA_W-1:0] reg_data;
    logic [TRC_ADDR_W-1:0] addr;
    logic [TRC_DATA_W-1:0] mem_data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO; occupancy counter drives full/empty.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop, do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  // Head reads as zero when empty so the stream outputs stay clean.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Retire-trace capture: packs core debug activity into sequenced records in a FIFO.
// Optional address/register filtering when TRACE_FILTER_EN is defined.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 9,
  parameter int REG_W        = 5,
  parameter int DEPTH        = 16,
  parameter int SEQ_W        = 16,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       reg_write_sig,
  input  logic [REG_W-1:0]           reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
`ifdef TRACE_FILTER_EN
  input  logic [ADDR_W-1:0]          filter_lo,
  input  logic [ADDR_W-1:0]          filter_hi,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_flags,
  output logic [REG_W-1:0]           out_reg,
  output logic [DATA_W-1:0]          out_reg_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_mem_data,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [SEQ_W-1:0]           overflow_cnt,
  output logic                       frozen
);

  localparam int REC_W = SEQ_W + 3 + REG_W + DATA_W + ADDR_W + DATA_W;

  trace_state_e     state, state_nxt;
  logic             run;
  logic [2:0]       flags;
  logic [DATA_W-1:0] mem_data;
  logic             mem_ok, reg_ok, event_hit, capture, pop, push, drop;
  logic             full, empty;
  logic [SEQ_W-1:0] seq;
  logic [REC_W-1:0] rec_in, rec_out;

`ifdef TRACE_FILTER_EN
  assign mem_ok = (addr >= filter_lo) && (addr <= filter_hi);
  assign reg_ok = (reg_num != '0);
`else
  assign mem_ok = 1'b1;
  assign reg_ok = 1'b1;
`endif

  // A store wins the data slot when a load happens in the same cycle.
  always_comb begin
    flags             = '0;
    flags[FLG_REG_WR] = reg_write_sig && reg_ok;
    flags[FLG_MEM_WR] = wr && mem_ok;
    flags[FLG_MEM_RD] = rd && mem_ok;
    if (flags[FLG_MEM_WR])      mem_data = wr_data;
    else if (flags[FLG_MEM_RD]) mem_data = rd_data;
    else                        mem_data = '0;
  end

  assign event_hit = |flags;
  assign capture   = run && event_hit && !clear;
  assign pop       = out_valid && out_ready;
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign rec_in    = {seq, flags, reg_num, reg_data, addr, mem_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state_nxt = RUN;
        RUN: begin
          if (drop && (STOP_ON_FULL != 0)) state_nxt = FROZEN;
          else if (!enable)                state_nxt = IDLE;
        end
        FROZEN:  state_nxt = FROZEN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    run    = (state == RUN);
    frozen = (state == FROZEN);
  end

  // Dropped events still consume a sequence number so gaps expose losses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq          <= '0;
      overflow_cnt <= '0;
    end else if (clear) begin
      seq          <= '0;
      overflow_cnt <= '0;
    end else begin
      if (capture) seq <= seq + 1'b1;
      if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (rec_in),
    .rdata (rec_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid = !empty;
  assign {out_seq, out_flags, out_reg, out_reg_data, out_addr, out_mem_data} = rec_out;

endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
- Parametrised retire-trace capture unit attached to the core's debug outputs: register-write strobe/number/data and data-memory wr/rd/addr/data.
- Packs each active cycle into one record and stores it in a DEPTH-entry FIFO.
- Records drain through a valid/ready stream port to a debug host or testbench monitor.
- Adds sequence numbering, drop counting, and a stop-on-full freeze mode.

Parameters:
- DATA_W, 32, width of register and memory data.
- ADDR_W, 9, data-memory address width.
- REG_W, 5, register-number width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SEQ_W, 16, sequence and overflow counter width.
- STOP_ON_FULL, 0, when 1 the first dropped event freezes capture.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  capture enable (level)
- clear  in  1  synchronous flush: empties FIFO, zeroes seq/overflow, FSM->IDLE
- reg_write_sig  in  1  register-file write strobe
- reg_num  in  REG_W  destination register
- reg_data  in  DATA_W  write-back data
- wr  in  1  data-memory write strobe
- rd  in  1  data-memory read strobe
- addr  in  ADDR_W  data-memory address
- wr_data  in  DATA_W  store data
- rd_data  in  DATA_W  load data
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head
- out_flags  out  3  {mem_rd, mem_wr, reg_wr} of head record
- out_reg  out  REG_W  head reg_num
- out_reg_data  out  DATA_W  head reg_data
- out_addr  out  ADDR_W  head addr
- out_mem_data  out  DATA_W  head memory data
- out_seq  out  SEQ_W  head sequence number
- count  out  $clog2(DEPTH+1)  occupancy
- overflow_cnt  out  SEQ_W  dropped-event count, saturating
- frozen  out  1  FSM in FROZEN

Behaviour:
- Reset (reset==0, async): FIFO empty, count=0, out_valid=0, all out_* data=0, seq=0, overflow_cnt=0, FSM=IDLE, frozen=0.
- Event: cycle with any of reg_write_sig, wr, rd high, sampled at posedge.
  - flags={rd,wr,reg_write_sig}.
  - mem_data = wr_data if wr, else rd_data if rd, else 0.
  - wr&rd together: both flags set, mem_data=wr_data.
- FSM states:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0.
  - RUN -> FROZEN on a drop when STOP_ON_FULL=1.
  - FROZEN -> IDLE only on clear.
  - Events are captured only in RUN.
- Sequence counter: each event in RUN takes the current seq and seq increments, whether the event is stored or dropped, so gaps reveal losses. Wraps modulo 2^SEQ_W.
- Push: event in RUN and (not full, or pop in the same cycle). When full, simultaneous pop+push is accepted and count is unchanged.
- Drop: event in RUN, full, and no pop. overflow_cnt increments and saturates at all-ones.
- Pop: out_valid & out_ready.
- Output is first-word-fall-through: an event at edge N gives out_valid=1 after edge N (one-cycle latency when empty). out_* are stable while out_valid & !out_ready.
- count: +1 on push, -1 on pop, unchanged on both; range 0..DEPTH.
- FROZEN: FIFO still drains; no new pushes, seq frozen.
- clear has priority over push/pop in the same cycle. Pending events in that cycle are discarded and not counted.
- enable falling with a pending event on that edge: the event is still captured, because the FSM is in RUN at that edge.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty come from count, not pointer compare.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- Defined:
  - Adds ports filter_lo and filter_hi (in, ADDR_W).
  - mem_wr/mem_rd flags are cleared when addr < filter_lo or addr > filter_hi; mem_data follows the cleared flags.
  - reg_wr is cleared when reg_num==0.
  - A cycle left with no flags is not an event: no seq increment, no drop.
- Undefined: no extra ports; all events are captured as specified above.

Decomposition:
- Package riscv_trace_pkg:
  - trace_rec_t packed struct {seq, flags, reg, reg_data, addr, mem_data}, parametrised via localparams matching the defaults.
  - trace_state_e enum {IDLE, RUN, FROZEN}.
  - Flag bit index constants FLG_REG_WR=0, FLG_MEM_WR=1, FLG_MEM_RD=2.
- Sub-module trace_fifo: generic synchronous FWFT FIFO (WIDTH, DEPTH, push/pop/full/empty/count, async active-low reset). The top holds the FSM, event packing, seq and overflow logic.

Test Plan:
1. Reset then enable=1; reg_write_sig=1, reg_num=5, reg_data=0x1234 for one cycle -> next cycle out_valid=1, out_flags=3'b001, out_reg=5, out_reg_data=0x1234, out_seq=0.
2. Same cycle wr=1, rd=1, addr=0x40, wr_data=0xAA, rd_data=0xBB -> out_flags=3'b110, out_addr=0x40, out_mem_data=0xAA.
3. out_ready=0, 18 consecutive events (DEPTH=16) -> count=16, overflow_cnt=2; then drain gives seq 0..15.
4. Full FIFO, out_ready=1 plus event in the same cycle -> count stays 16, overflow_cnt unchanged, tail out_seq increments.
5. STOP_ON_FULL=1: fill, one extra event -> frozen=1; further events not stored and seq unchanged; clear -> count=0, overflow_cnt=0, frozen=0, FSM=IDLE.
6. Assert reset low mid-drain with count=7 -> out_valid=0, count=0, seq=0 immediately; with TRACE_FILTER_EN, filter 0x10..0x1F and addr=0x20 write -> no record.
